// File: rtl/axi4_lite_reg_slave_if.sv
// rtl/axi4_lite_reg_slave_if.sv - AXI4-Lite bus bundle between driver and register slave
// Purpose: groups the five AXI4-Lite channels; i_/o_ prefixes are from the slave's view.
// Ports:   AR/R read channels, AW/W/B write channels; modports slave and master.

interface axi4_lite_reg_slave_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
) ();
  localparam int SWIDTH = DWIDTH / 8;

  logic              i_arValid;
  logic              o_arReady;
  logic [AWIDTH-1:0] i_arAddr;
  logic [2:0]        i_arProt;

  logic              o_rValid;
  logic              i_rReady;
  logic [DWIDTH-1:0] o_rData;
  logic [1:0]        o_rResp;

  logic              i_awValid;
  logic              o_awReady;
  logic [AWIDTH-1:0] i_awAddr;
  logic [2:0]        i_awProt;

  logic              i_wValid;
  logic              o_wReady;
  logic [DWIDTH-1:0] i_wData;
  logic [SWIDTH-1:0] i_wStrb;

  logic              o_bValid;
  logic              i_bReady;
  logic [1:0]        o_bResp;

  modport slave (
    input  i_arValid, i_arAddr, i_arProt, i_rReady,
    input  i_awValid, i_awAddr, i_awProt, i_wValid, i_wData, i_wStrb, i_bReady,
    output o_arReady, o_rValid, o_rData, o_rResp,
    output o_awReady, o_wReady, o_bValid, o_bResp
  );

  modport master (
    output i_arValid, i_arAddr, i_arProt, i_rReady,
    output i_awValid, i_awAddr, i_awProt, i_wValid, i_wData, i_wStrb, i_bReady,
    input  o_arReady, o_rValid, o_rData, o_rResp,
    input  o_awReady, o_wReady, o_bValid, o_bResp
  );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// rtl/axi4_lite_reg_slave.sv - AXI4-Lite register bank slave with DECERR for unmapped words
// Purpose: NREGS read/write registers exposed as a flat vector, with per-register write pulses.
// Ports:   i_aClk, i_aReset (sync, active high); bus (AXI4-Lite slave modport);
//          o_regs (reg k at [k*DWIDTH +: DWIDTH]); o_wrPulse (one cycle after commit of reg k).

module axi4_lite_reg_slave #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32,
  parameter int SWIDTH = DWIDTH / 8,
  parameter int NREGS  = 8
) (
  input  logic                    i_aClk,
  input  logic                    i_aReset,
  axi4_lite_reg_slave_if.slave    bus,
  output logic [NREGS*DWIDTH-1:0] o_regs,
  output logic [NREGS-1:0]        o_wrPulse
);
  localparam int ALSB = $clog2(SWIDTH);
  localparam int IW   = AWIDTH - ALSB;
  localparam int IWP  = IW + 1;
  // One extra bit so NREGS == 2^IW still compares correctly.
  localparam logic [IW:0] C_NREGS     = IWP'(NREGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  wr_state_t         r_wr_state;
  wr_state_t         w_wr_next;

  logic [DWIDTH-1:0] r_regs [NREGS];
  logic [IW-1:0]     r_aw_idx;
  logic [DWIDTH-1:0] r_w_data;
  logic [SWIDTH-1:0] r_w_strb;
  logic [1:0]        r_bresp;
  logic [NREGS-1:0]  r_wr_pulse;
  logic              r_rvalid;
  logic [DWIDTH-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic              w_aw_ready;
  logic              w_w_ready;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic              w_bvalid;
  logic              w_aw_in_range;
  logic              w_ar_hs;
  logic [IW-1:0]     w_ar_idx;
  logic              w_ar_in_range;
  logic [DWIDTH-1:0] w_ar_data;
  logic              w_unused_ok;

  // Write channel FSM: HAVE_AW / HAVE_W are the "held" flags; COMMIT is the
  // edge after both are held; RESP is the B-valid phase.
  always_ff @(posedge i_aClk) begin
    if (i_aReset) begin
      r_wr_state <= WR_IDLE;
    end else begin
      r_wr_state <= w_wr_next;
    end
  end

  always_comb begin
    w_wr_next  = r_wr_state;
    w_aw_ready = 1'b0;
    w_w_ready  = 1'b0;
    w_commit   = 1'b0;
    w_bvalid   = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        w_aw_ready = !i_aReset;
        w_w_ready  = !i_aReset;
        if (bus.i_awValid && bus.i_wValid) begin
          w_wr_next = WR_COMMIT;
        end else if (bus.i_awValid) begin
          w_wr_next = WR_HAVE_AW;
        end else if (bus.i_wValid) begin
          w_wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        w_w_ready = !i_aReset;
        if (bus.i_wValid) begin
          w_wr_next = WR_COMMIT;
        end
      end
      WR_HAVE_W: begin
        w_aw_ready = !i_aReset;
        if (bus.i_awValid) begin
          w_wr_next = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        w_commit  = 1'b1;
        w_wr_next = WR_RESP;
      end
      WR_RESP: begin
        w_bvalid = 1'b1;
        if (bus.i_bReady) begin
          w_wr_next = WR_IDLE;
        end
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  assign w_aw_hs       = bus.i_awValid && w_aw_ready;
  assign w_w_hs        = bus.i_wValid && w_w_ready;
  assign w_aw_in_range = {1'b0, r_aw_idx} < C_NREGS;

  always_ff @(posedge i_aClk) begin
    r_wr_pulse <= '0;
    if (w_aw_hs) begin
      r_aw_idx <= bus.i_awAddr[AWIDTH-1:ALSB];
    end
    if (w_w_hs) begin
      r_w_data <= bus.i_wData;
      r_w_strb <= bus.i_wStrb;
    end
    if (w_commit) begin
      if (w_aw_in_range) begin
        r_bresp <= RESP_OKAY;
        for (int k = 0; k < NREGS; k++) begin
          if (r_aw_idx == IW'(k)) begin
            r_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < SWIDTH; b++) begin
              if (r_w_strb[b]) begin
                r_regs[k][8*b +: 8] <= r_w_data[8*b +: 8];
              end
            end
          end
        end
      end else begin
        r_bresp <= RESP_DECERR;
      end
    end
    if (i_aReset) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
      r_wr_pulse <= '0;
      r_bresp    <= RESP_OKAY;
    end
  end

  // Read path: single outstanding read, data captured at the AR handshake.
  assign w_ar_hs       = bus.i_arValid && !r_rvalid && !i_aReset;
  assign w_ar_idx      = bus.i_arAddr[AWIDTH-1:ALSB];
  assign w_ar_in_range = {1'b0, w_ar_idx} < C_NREGS;

  always_comb begin
    w_ar_data = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (w_ar_idx == IW'(k)) begin
        w_ar_data = r_regs[k];
      end
    end
  end

  always_ff @(posedge i_aClk) begin
    if (i_aReset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_data;
      r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_DECERR;
    end else if (r_rvalid && bus.i_rReady) begin
      r_rvalid <= 1'b0;
    end
  end

  assign bus.o_arReady = !i_aReset && !r_rvalid;
  assign bus.o_rValid  = r_rvalid;
  assign bus.o_rData   = r_rdata;
  assign bus.o_rResp   = r_rresp;
  assign bus.o_awReady = w_aw_ready;
  assign bus.o_wReady  = w_w_ready;
  assign bus.o_bValid  = w_bvalid;
  assign bus.o_bResp   = r_bresp;

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign o_regs[g*DWIDTH +: DWIDTH] = r_regs[g];
  end
  assign o_wrPulse = r_wr_pulse;

  // Protection bits and sub-word address bits carry no meaning here.
  assign w_unused_ok = ^{bus.i_arProt, bus.i_awProt,
                         bus.i_arAddr[ALSB-1:0], bus.i_awAddr[ALSB-1:0]};
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// tb/tb_axi4_lite_reg_slave.sv - directed bench with transaction-level model for axi4_lite_reg_slave

module tb_axi4_lite_reg_slave;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] regs;
  logic [7:0]   pulse;

  always #5 clk = ~clk;

  axi4_lite_reg_slave_if #(.AWIDTH(12), .DWIDTH(32)) bus ();

  axi4_lite_reg_slave #(
    .AWIDTH(12), .DWIDTH(32), .SWIDTH(4), .NREGS(8)
  ) dut (
    .i_aClk   (clk),
    .i_aReset (rst),
    .bus      (bus),
    .o_regs   (regs),
    .o_wrPulse(pulse)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level model of the slave.
  logic [31:0] m_regs [8];
  logic [7:0]  m_pulse;
  bit          m_aw_h, m_w_h, m_b_pend, m_r_pend, m_on;
  logic [11:0] m_aw_addr;
  logic [31:0] m_w_data, m_rdata;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_bresp, m_rresp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit          aw_acc, w_acc, ar_acc, b_rdy, r_rdy, rst_s;
    logic [11:0] aw_a, ar_a;
    logic [31:0] w_d, mask;
    logic [3:0]  w_s;
    int          idx;
    rst_s  = rst;
    aw_acc = bus.i_awValid && !m_aw_h && !m_b_pend;
    w_acc  = bus.i_wValid && !m_w_h && !m_b_pend;
    ar_acc = bus.i_arValid && !m_r_pend;
    b_rdy  = bus.i_bReady;
    r_rdy  = bus.i_rReady;
    aw_a   = bus.i_awAddr;
    ar_a   = bus.i_arAddr;
    w_d    = bus.i_wData;
    w_s    = bus.i_wStrb;
    @(posedge clk);
    m_pulse = 8'h00;
    if (rst_s) begin
      for (int k = 0; k < 8; k++) m_regs[k] = 32'h0;
      m_aw_h = 0; m_w_h = 0; m_b_pend = 0; m_r_pend = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0;
      m_on = 1;
    end else begin
      // Read sees register contents from before any write committed this edge.
      if (ar_acc) begin
        idx = int'(ar_a) / 4;
        m_r_pend = 1;
        m_rdata  = (idx < 8) ? m_regs[idx] : 32'h0;
        m_rresp  = (idx < 8) ? 2'b00 : 2'b11;
      end else if (m_r_pend && r_rdy) begin
        m_r_pend = 0;
      end
      if (m_aw_h && m_w_h) begin
        idx = int'(m_aw_addr) / 4;
        if (idx < 8) begin
          mask = {{8{m_w_strb[3]}}, {8{m_w_strb[2]}}, {8{m_w_strb[1]}}, {8{m_w_strb[0]}}};
          m_regs[idx] = (m_regs[idx] & ~mask) | (m_w_data & mask);
          m_pulse = 8'(1 << idx);
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b11;
        end
        m_b_pend = 1; m_aw_h = 0; m_w_h = 0;
      end else if (m_b_pend && b_rdy) begin
        m_b_pend = 0;
      end
      if (aw_acc) begin m_aw_h = 1; m_aw_addr = aw_a; end
      if (w_acc) begin m_w_h = 1; m_w_data = w_d; m_w_strb = w_s; end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("reg%0d", k), 64'(regs[k*32 +: 32]), 64'(m_regs[k]));
      chk("wrPulse", 64'(pulse), 64'(m_pulse));
      chk("bValid", 64'(bus.o_bValid), 64'(m_b_pend));
      if (m_b_pend) chk("bResp", 64'(bus.o_bResp), 64'(m_bresp));
      chk("rValid", 64'(bus.o_rValid), 64'(m_r_pend));
      if (m_r_pend) begin
        chk("rData", 64'(bus.o_rData), 64'(m_rdata));
        chk("rResp", 64'(bus.o_rResp), 64'(m_rresp));
      end
      chk("arReady", 64'(bus.o_arReady), 64'(!rst && !m_r_pend));
      chk("awReady", 64'(bus.o_awReady), 64'(!rst && !m_aw_h && !m_b_pend));
      chk("wReady", 64'(bus.o_wReady), 64'(!rst && !m_w_h && !m_b_pend));
    end
  end

  task automatic write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_go, w_go;
    bus.i_awValid = 1'b1; bus.i_awAddr = a;
    bus.i_wValid  = 1'b1; bus.i_wData  = d; bus.i_wStrb = s;
    for (int i = 0; i < 20 && (bus.i_awValid || bus.i_wValid); i++) begin
      aw_go = bus.o_awReady;
      w_go  = bus.o_wReady;
      tick();
      if (aw_go) bus.i_awValid = 1'b0;
      if (w_go)  bus.i_wValid  = 1'b0;
    end
    if (bus.i_awValid || bus.i_wValid) begin
      chk("write_timeout", 64'd1, 64'd0);
      bus.i_awValid = 1'b0; bus.i_wValid = 1'b0;
    end
  endtask

  task automatic read(input logic [11:0] a);
    bit ar_go;
    bus.i_arValid = 1'b1; bus.i_arAddr = a;
    for (int i = 0; i < 20 && bus.i_arValid; i++) begin
      ar_go = bus.o_arReady;
      tick();
      if (ar_go) bus.i_arValid = 1'b0;
    end
    if (bus.i_arValid) begin
      chk("read_timeout", 64'd1, 64'd0);
      bus.i_arValid = 1'b0;
    end
  endtask

  logic [255:0] snap;

  initial begin
    m_on = 0; m_pulse = 8'h00;
    rst = 1'b1;
    bus.i_arValid = 0; bus.i_arAddr = '0; bus.i_arProt = '0; bus.i_rReady = 1;
    bus.i_awValid = 0; bus.i_awAddr = '0; bus.i_awProt = 3'b101;
    bus.i_wValid  = 0; bus.i_wData  = '0; bus.i_wStrb  = '0; bus.i_bReady = 1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset then idle
    chk("rst_regs_nonzero", 64'(|regs), 64'd0);
    chk("idle_arReady", 64'(bus.o_arReady), 64'd1);
    chk("idle_awReady", 64'(bus.o_awReady), 64'd1);
    chk("idle_wReady", 64'(bus.o_wReady), 64'd1);

    // Simultaneous AW/W, full strobe
    write(12'h004, 32'hDEADBEEF, 4'hF);
    chk("s2_no_b_yet", 64'(bus.o_bValid), 64'd0);
    tick();
    chk("s2_reg1", 64'(regs[63:32]), 64'hDEADBEEF);
    chk("s2_bValid", 64'(bus.o_bValid), 64'd1);
    chk("s2_bResp", 64'(bus.o_bResp), 64'd0);
    chk("s2_pulse", 64'(pulse), 64'h02);
    tick();
    chk("s2_pulse_gone", 64'(pulse), 64'h00);
    read(12'h004);
    chk("s2_rData", 64'(bus.o_rData), 64'hDEADBEEF);
    chk("s2_rResp", 64'(bus.o_rResp), 64'd0);
    tick();

    // W three cycles before AW, partial strobe
    write(12'h008, 32'hAAAAAAAA, 4'hF);
    tick(); tick();
    chk("s3_preload", 64'(regs[95:64]), 64'hAAAAAAAA);
    bus.i_wValid = 1; bus.i_wData = 32'h11223344; bus.i_wStrb = 4'b0101;
    tick();
    bus.i_wValid = 0;
    chk("s3_wReady_low", 64'(bus.o_wReady), 64'd0);
    tick(); tick();
    bus.i_awValid = 1; bus.i_awAddr = 12'h00A;
    tick();
    bus.i_awValid = 0;
    tick();
    chk("s3_reg2", 64'(regs[95:64]), 64'hAA22AA44);
    chk("s3_pulse", 64'(pulse), 64'h04);
    tick(); tick(); tick();
    chk("s3_single_b", 64'(bus.o_bValid), 64'd0);

    // Out-of-range write and read
    snap = regs;
    write(12'h020, 32'h12345678, 4'hF);
    tick();
    chk("s4_bResp", 64'(bus.o_bResp), 64'd3);
    chk("s4_no_pulse", 64'(pulse), 64'h00);
    tick();
    read(12'h3FC);
    chk("s4_rResp", 64'(bus.o_rResp), 64'd3);
    chk("s4_rData", 64'(bus.o_rData), 64'd0);
    tick();
    chk("s4_regs_same", 64'(regs != snap), 64'd0);

    // Back-pressure; read of reg3 coincides with its commit and sees the old value
    bus.i_bReady = 0; bus.i_rReady = 0;
    write(12'h00C, 32'hCAFEF00D, 4'hF);
    read(12'h00C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s5_bValid_held", 64'(bus.o_bValid), 64'd1);
      chk("s5_rData_old", 64'(bus.o_rData), 64'd0);
      chk("s5_arReady", 64'(bus.o_arReady), 64'd0);
      chk("s5_awReady", 64'(bus.o_awReady), 64'd0);
    end
    bus.i_bReady = 1; bus.i_rReady = 1;
    tick();
    chk("s5_b_released", 64'(bus.o_bValid), 64'd0);
    chk("s5_r_released", 64'(bus.o_rValid), 64'd0);
    read(12'h00C);
    chk("s5_reg3_read", 64'(bus.o_rData), 64'hCAFEF00D);
    tick();

    // Reset mid-transaction
    bus.i_bReady = 0; bus.i_rReady = 0;
    bus.i_awValid = 1; bus.i_awAddr = 12'h010;
    tick();
    bus.i_awValid = 0;
    read(12'h004);
    chk("s6_r_pending", 64'(bus.o_rValid), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("s6_rValid", 64'(bus.o_rValid), 64'd0);
    chk("s6_bValid", 64'(bus.o_bValid), 64'd0);
    chk("s6_regs_zero", 64'(|regs), 64'd0);
    tick();
    bus.i_bReady = 1; bus.i_rReady = 1;
    bus.i_wValid = 1; bus.i_wData = 32'h00000055; bus.i_wStrb = 4'hF;
    tick();
    bus.i_wValid = 0;
    tick(); tick();
    chk("s6_no_b_without_aw", 64'(bus.o_bValid), 64'd0);
    bus.i_awValid = 1; bus.i_awAddr = 12'h010;
    tick();
    bus.i_awValid = 0;
    tick();
    chk("s6_b_after_aw", 64'(bus.o_bValid), 64'd1);
    chk("s6_reg4", 64'(regs[159:128]), 64'h55);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
